fanout_fork: RTL and testbench

Parametrised eager/lazy fork for the streaming fabric: registers one token from a single upstream producer and broadcasts it to up to `NUM_OUT` downstream consumers. Per-channel enable and config-select bits determine which consumers participate; non-participating channels count as permanently ready. In eager mode, per-channel completion is tracked so each consumer sees the token exactly once, and consumers may accept in different cycles. The block sits between a primitive's output port and the fanout routing it drives.

---
 rtl/fanout_pkg.sv | 14 +
 rtl/fanout_done_tracker.sv | 42 ++++
 rtl/fanout_fork.sv | 109 ++++++++++
 tb/tb_fanout_fork.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fanout_pkg.sv
// Shared types and limits for the fanout fork.
package fanout_pkg;

    // Fork discipline: lazy waits for all active consumers together,
    // eager lets each consumer take the token in its own cycle.
    typedef enum logic {
        FANOUT_LAZY  = 1'b0,
        FANOUT_EAGER = 1'b1
    } fanout_mode_e;

    // Upper bound on the number of downstream channels.
    localparam int FANOUT_MAX_OUT = 64;

endpackage

// File: rtl/fanout_done_tracker.sv
// Per-channel completion tracking and token release for the fanout fork.
// done[i] records that channel i already took the current token (eager only);
// rel fires when every channel is inactive, done, or ready right now.
module fanout_done_tracker
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = 22
) (
    input  logic               clk,
    input  logic               reset,
    input  fanout_mode_e       mode,
    input  logic               hold_valid,
    input  logic [NUM_OUT-1:0] act,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [NUM_OUT-1:0] done,
    output logic               rel
);

    logic [NUM_OUT-1:0] ok;
    logic [NUM_OUT-1:0] accept;

    // A channel no longer blocks release once it is inactive, served, or ready.
    always_comb begin
        ok     = ~act | done | out_ready;
        rel    = hold_valid & (&ok);
        accept = {NUM_OUT{hold_valid}} & act & ~done & out_ready;
    end

    // Completion bits: cleared on release, in lazy mode, and for inactive channels.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= '0;
        end else if (mode == FANOUT_LAZY) begin
            done <= '0;
        end else if (rel) begin
            done <= '0;
        end else begin
            done <= (done | accept) & act;
        end
    end

endmodule

// File: rtl/fanout_fork.sv
// Eager/lazy fork: holds one upstream token and broadcasts it to NUM_OUT
// consumers selected by cfg_en & cfg_sel.
// Optional build macro FANOUT_FORK_STATS_EN adds a saturating stall counter
// on port stall_count (cycles with a held token that is not released).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready from the same side except lazy
// out_valid, which by design looks at the other consumers' out_ready.
module fanout_fork
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = 22,
    parameter int DATA_W  = 32
`ifdef FANOUT_FORK_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_OUT-1:0] cfg_en,
    input  logic [NUM_OUT-1:0] cfg_sel,
    input  logic               cfg_eager,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [NUM_OUT-1:0] out_ready
`ifdef FANOUT_FORK_STATS_EN
    ,
    output logic [CNT_W-1:0]   stall_count
`endif
);

    if (NUM_OUT < 1 || NUM_OUT > FANOUT_MAX_OUT) begin : g_bad_num_out
        $error("fanout_fork: NUM_OUT out of range");
    end

    fanout_mode_e       mode;
    logic [NUM_OUT-1:0] act;
    logic [NUM_OUT-1:0] done;
    logic [NUM_OUT-1:0] lazy_ok;
    logic               rel;
    logic               hold_valid;
    logic [DATA_W-1:0]  hold_data;

    assign mode     = fanout_mode_e'(cfg_eager);
    assign act      = cfg_en & cfg_sel;
    assign in_ready = ~hold_valid | rel;
    assign out_data = hold_data;

    fanout_done_tracker #(
        .NUM_OUT (NUM_OUT)
    ) u_done_tracker (
        .clk        (CLK),
        .reset      (RESET),
        .mode       (mode),
        .hold_valid (hold_valid),
        .act        (act),
        .out_ready  (out_ready),
        .done       (done),
        .rel        (rel)
    );

    // Per-channel valid: eager masks served channels, lazy waits on all others.
    always_comb begin
        logic [NUM_OUT-1:0] others;
        lazy_ok   = ~act | out_ready;
        others    = lazy_ok;
        out_valid = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            others    = lazy_ok;
            others[i] = 1'b1;
            if (mode == FANOUT_EAGER) begin
                out_valid[i] = hold_valid & act[i] & ~done[i];
            end else begin
                out_valid[i] = hold_valid & act[i] & (&others);
            end
        end
    end

    // Holding register: load wins over release so tokens stream back to back.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (in_valid && in_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= in_data;
        end else if (rel) begin
            hold_valid <= 1'b0;
        end
    end

`ifdef FANOUT_FORK_STATS_EN
    // Stall counter: saturates at all-ones, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_count <= '0;
        end else if (hold_valid && !rel && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`else
    // No statistics counter in this build.
`endif

endmodule

// File: tb/tb_fanout_fork.sv
// Directed bench for fanout_fork with four channels.
module tb_fanout_fork;

    localparam int N = 4;
    localparam int W = 32;

    logic         CLK;
    logic         RESET;
    logic [N-1:0] cfg_en;
    logic [N-1:0] cfg_sel;
    logic         cfg_eager;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [N-1:0] out_valid;
    logic [W-1:0] out_data;
    logic [N-1:0] out_ready;
`ifdef FANOUT_FORK_STATS_EN
    logic [15:0]  stall_count;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    fanout_fork #(
        .NUM_OUT (N),
        .DATA_W  (W)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .cfg_en      (cfg_en),
        .cfg_sel     (cfg_sel),
        .cfg_eager   (cfg_eager),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
`ifdef FANOUT_FORK_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        step();
        step();
        RESET = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        cfg_en    = 4'b1111;
        cfg_sel   = 4'b1111;
        cfg_eager = 1'b1;
        do_reset();
        chk_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL reset_out_valid got=%b exp=%b", out_valid, 4'b0000);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== 32'h0) $display("FAIL reset_out_data got=%h exp=0", out_data);
        else pass_cnt++;
    endtask

    task automatic test_eager();
        int beats [N];
        for (int i = 0; i < N; i++) beats[i] = 0;
        cfg_en = 4'b1111; cfg_sel = 4'b1111; cfg_eager = 1'b1;
        in_valid = 1'b1; in_data = 32'h11; out_ready = 4'b0000;
        step();
        in_valid = 1'b0; out_ready = 4'b0101;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b1111) $display("FAIL eager_c1_valid got=%b exp=%b", out_valid, 4'b1111);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL eager_c1_in_ready got=%b exp=0", in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== 32'h11) $display("FAIL eager_c1_data got=%h exp=11", out_data);
        else pass_cnt++;
        for (int i = 0; i < N; i++) if (out_valid[i] && out_ready[i]) beats[i]++;
        step();
        out_ready = 4'b1010;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b1010) $display("FAIL eager_c2_valid got=%b exp=%b", out_valid, 4'b1010);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL eager_c2_in_ready got=%b exp=1", in_ready);
        else pass_cnt++;
        for (int i = 0; i < N; i++) if (out_valid[i] && out_ready[i]) beats[i]++;
        step();
        out_ready = 4'b0000;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL eager_c3_valid got=%b exp=%b", out_valid, 4'b0000);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            chk_cnt++;
            if (beats[i] !== 1) $display("FAIL eager_beats ch=%0d got=%0d exp=1", i, beats[i]);
            else pass_cnt++;
        end
        // done must be clear: a fresh token is offered to every channel.
        in_valid = 1'b1; in_data = 32'h22;
        step();
        in_valid = 1'b0;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b1111) $display("FAIL eager_done_clear got=%b exp=%b", out_valid, 4'b1111);
        else pass_cnt++;
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
    endtask

    task automatic test_lazy();
        cfg_en = 4'b1111; cfg_sel = 4'b1111; cfg_eager = 1'b0;
        in_valid = 1'b1; in_data = 32'h33; out_ready = 4'b0000;
        step();
        in_valid = 1'b0; out_ready = 4'b0101;
        #1;
        chk_cnt++;
        if ((out_valid & out_ready) !== 4'b0000) $display("FAIL lazy_c1_hs got=%b exp=%b", out_valid & out_ready, 4'b0000);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL lazy_c1_in_ready got=%b exp=0", in_ready);
        else pass_cnt++;
        step();
        out_ready = 4'b1010;
        #1;
        chk_cnt++;
        if ((out_valid & out_ready) !== 4'b0000) $display("FAIL lazy_c2_hs got=%b exp=%b", out_valid & out_ready, 4'b0000);
        else pass_cnt++;
        step();
        out_ready = 4'b0111;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b1000) $display("FAIL lazy_c3_valid got=%b exp=%b", out_valid, 4'b1000);
        else pass_cnt++;
        step();
        out_ready = 4'b1111;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b1111) $display("FAIL lazy_c4_valid got=%b exp=%b", out_valid, 4'b1111);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL lazy_c4_in_ready got=%b exp=1", in_ready);
        else pass_cnt++;
        step();
        out_ready = 4'b0000;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL lazy_after_valid got=%b exp=%b", out_valid, 4'b0000);
        else pass_cnt++;
    endtask

    task automatic test_partial_select();
        cfg_en = 4'b1111; cfg_sel = 4'b0011; cfg_eager = 1'b1;
        in_valid = 1'b1; in_data = 32'h44; out_ready = 4'b0000;
        step();
        in_valid = 1'b0; out_ready = 4'b0011;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b0011) $display("FAIL sel_valid got=%b exp=%b", out_valid, 4'b0011);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL sel_in_ready got=%b exp=1", in_ready);
        else pass_cnt++;
        step();
        out_ready = 4'b0000;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL sel_after_valid got=%b exp=%b", out_valid, 4'b0000);
        else pass_cnt++;
    endtask

    task automatic test_all_inactive();
        cfg_en = 4'b0000; cfg_sel = 4'b0000; cfg_eager = 1'b1;
        out_ready = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_data = k;
            #1;
            chk_cnt++;
            if (in_ready !== 1'b1) $display("FAIL drop_in_ready k=%0d got=%b exp=1", k, in_ready);
            else pass_cnt++;
            chk_cnt++;
            if (out_valid !== 4'b0000) $display("FAIL drop_valid k=%0d got=%b exp=0000", k, out_valid);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (out_data !== k) $display("FAIL drop_data k=%0d got=%h exp=%h", k, out_data, k);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        cfg_en = 4'b1111; cfg_sel = 4'b1111; cfg_eager = 1'b1;
        out_ready = 4'b1111;
        in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        #1;
        chk_cnt++;
        if (out_data !== 32'hA) $display("FAIL b2b_data_a got=%h exp=a", out_data);
        else pass_cnt++;
        chk_cnt++;
        if (out_valid !== 4'b1111) $display("FAIL b2b_valid_a got=%b exp=1111", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready_a got=%b exp=1", in_ready);
        else pass_cnt++;
        step();
        in_valid = 1'b0;
        #1;
        chk_cnt++;
        if (out_data !== 32'hB) $display("FAIL b2b_data_b got=%h exp=b", out_data);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready_b got=%b exp=1", in_ready);
        else pass_cnt++;
        step();
        #1;
        chk_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL b2b_drained got=%b exp=0000", out_valid);
        else pass_cnt++;
        out_ready = 4'b0000;
    endtask

    task automatic test_reset_mid_token();
        cfg_en = 4'b1111; cfg_sel = 4'b1111; cfg_eager = 1'b1;
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 32'h66;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk_cnt++;
        if (out_valid !== 4'b1111) $display("FAIL stall_valid got=%b exp=1111", out_valid);
        else pass_cnt++;
`ifdef FANOUT_FORK_STATS_EN
        chk_cnt++;
        if (stall_count !== 16'd5) $display("FAIL stall_count got=%0d exp=5", stall_count);
        else pass_cnt++;
`endif
        // Reset takes priority over a simultaneous load.
        RESET = 1'b1; in_valid = 1'b1; in_data = 32'h77;
        step();
        RESET = 1'b0; in_valid = 1'b0;
        #1;
        chk_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL rst_mid_valid got=%b exp=0000", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== 32'h0) $display("FAIL rst_mid_data got=%h exp=0", out_data);
        else pass_cnt++;
`ifdef FANOUT_FORK_STATS_EN
        chk_cnt++;
        if (stall_count !== 16'd0) $display("FAIL rst_stall_count got=%0d exp=0", stall_count);
        else pass_cnt++;
`endif
        out_ready = 4'b1111;
        step();
        chk_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL no_redeliver got=%b exp=0000", out_valid);
        else pass_cnt++;
        out_ready = 4'b0000;
    endtask

    initial begin
        RESET = 1'b1; cfg_en = '0; cfg_sel = '0; cfg_eager = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = '0;
        test_reset();
        test_eager();
        test_lazy();
        test_partial_select();
        test_all_inactive();
        test_back_to_back();
        test_reset_mid_token();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
